// File: rtl/serial_add_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_pkg
//
// Purpose:
//   Shared definitions for the bit-serial adder controller: the FSM state
//   encoding and the rule that sizes the bit counter.
//
// Contents:
//   state_e       - FSM states (IDLE=0, RUN=1, DONE=2; encoding 3 is illegal
//                   and the controller recovers from it to IDLE)
//   cnt_width()   - counter width for a given operand width, $clog2(w+1)
// ---------------------------------------------------------------------------
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The counter must be able to hold the value WIDTH, hence WIDTH+1.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage : serial_add_ctrl_pkg

// File: rtl/serial_add_ctrl_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//
// Purpose:
//   Single-bit full adder. The serial adder controller time-multiplexes one
//   instance of this cell across all bit positions of the operands.
//
// Ports:
//   A, B  (in)  operand bits
//   Cin   (in)  carry in
//   S     (out) sum bit,   A ^ B ^ Cin
//   Cout  (out) carry out, majority(A, B, Cin)
// ---------------------------------------------------------------------------
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    logic half_sum;

    assign half_sum = A ^ B;
    assign S        = half_sum ^ Cin;
    // Generate when both operand bits are set, propagate the incoming carry
    // when exactly one is set.
    assign Cout     = (A & B) | (Cin & half_sum);

endmodule : full_adder

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Purpose:
//   Bit-serial adder controller. A start pulse in IDLE captures A, B and Cin;
//   the block then feeds one bit pair per clock (LSB first) through a single
//   full_adder, with the carry held in a flip-flop between bits. After WIDTH
//   bit steps the sum and final carry are written to S/Cout and done pulses
//   for one cycle. Throughput is one operation every WIDTH+2 cycles.
//
// Configuration:
//   WIDTH              operand/result width, legal range 2..32 (default 8)
//   SERIAL_ADD_SUB_EN  when defined, adds the Sub input. Sub=1 computes
//                      A - B (B inverted, carry-in forced to 1, Cin ignored);
//                      Cout=1 then means no borrow. Sub=0 behaves exactly like
//                      the add-only build.
//
// Ports:
//   clk    (in)  rising-edge clock
//   rst    (in)  asynchronous active-high reset, clears all state
//   start  (in)  operation request, only looked at in IDLE
//   A, B   (in)  operands, captured on the accepting edge
//   Cin    (in)  initial carry, captured on the accepting edge
//   Sub    (in)  subtract select (SERIAL_ADD_SUB_EN builds only)
//   busy   (out) high in RUN and DONE
//   done   (out) one-cycle pulse; S/Cout are valid from this cycle on
//   S      (out) registered sum, held until the next done
//   Cout   (out) registered final carry, held until the next done
// ---------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             Sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    // The last RUN step is the one taken while the counter shows WIDTH-1.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    logic [WIDTH-1:0]   s_sh_q,   s_sh_d;
    logic               carry_q,  carry_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   s_q,      s_d;
    logic               cout_q,   cout_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    // -----------------------------------------------------------------------
    // Operand capture values. In subtract mode B is inverted and the initial
    // carry forced to 1, turning the adder into A + ~B + 1 = A - B.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

`ifdef SERIAL_ADD_SUB_EN
    assign b_load     = Sub ? ~B : B;
    assign carry_load = Sub ? 1'b1 : Cin;
`else
    assign b_load     = B;
    assign carry_load = Cin;
`endif

    // -----------------------------------------------------------------------
    // The one shared full adder, always looking at the current LSBs.
    // -----------------------------------------------------------------------
    logic fa_s;
    logic fa_cout;

    full_adder u_full_adder (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // Sum register after this step: new bit enters at the MSB so that after
    // WIDTH steps the first (LSB) sum bit has arrived at bit 0.
    logic [WIDTH-1:0] s_sh_next;
    assign s_sh_next = {fa_s, s_sh_q[WIDTH-1:1]};

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every target gets a hold value first so no path through the
        // case leaves a signal unassigned, which would infer a latch.
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_sh_d  = A;
                    b_sh_d  = b_load;
                    carry_d = carry_load;
                    s_sh_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                s_sh_d  = s_sh_next;
                carry_d = fa_cout;
                cnt_d   = cnt_q + 1'b1;
                busy_d  = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Result is published on the same edge that enters DONE,
                    // so S/Cout and done become visible together.
                    s_d     = s_sh_next;
                    cout_d  = fa_cout;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                // Illegal encoding: drop back to a clean IDLE.
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers (FSM, datapath and registered outputs)
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so all
    // flops sample the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Cout = cout_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Self-checking bench for serial_add_ctrl (WIDTH=8). Expected results come
// from a plain-arithmetic model of {Cout,S} = A + B + Cin (or A - B with the
// subtract option). Inputs are driven and outputs sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Sub;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
`ifdef SERIAL_ADD_SUB_EN
        .Sub   (Sub),
`endif
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: result as an integer of W+1 bits.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
        int unsigned r;
        if (sub) begin
            r = (a >= b) ? (32'h1 << W) : 0;
            r = r + ((a - b) & ((32'h1 << W) - 1));
        end else begin
            r = int'(a) + int'(b) + int'(cin);
        end
        return r[W:0];
    endfunction

    // Issue one operation and follow it to completion. Returns the number of
    // edges from the accepting edge to the first done, the number of cycles
    // busy was high, the number of done pulses, and S/Cout seen at done.
    // lat stays -1 if done never came within the budget.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, output int lat, output int busy_cnt,
                         output int done_cnt, output logic [W:0] res);
        @(negedge clk);
        A = a; B = b; Cin = cin; Sub = sub; start = 1'b1;
        @(negedge clk);                      // accepting edge has passed
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
        lat = -1; done_cnt = 0; res = '0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 1; i <= 4 * W; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = i;
                    res = {Cout, S};
                end
            end
            if (!busy) break;
        end
        Sub = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, Cout, S} !== {3'b000, {W{1'b0}}}) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: busy=%b done=%b Cout=%b S=%h, expected all zero",
                         i, busy, done, Cout, S);
            end
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4] = '{8'h0F, 8'hFF, 8'hFF, 8'h00};
        logic [W-1:0] tb [4] = '{8'h01, 8'h01, 8'hFF, 8'h00};
        logic         tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [W:0]   ex [4] = '{9'h010, 9'h100, 9'h1FF, 9'h001};
        int lat, bc, dc;
        logic [W:0] res;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], tc[i], 1'b0, lat, bc, dc, res);
            checks++;
            if (lat !== W) begin
                errors++;
                $display("FAIL dir_latency[%0d]: done %0d edges after accept, expected %0d", i, lat, W);
            end
            checks++;
            if (bc !== W + 1) begin
                errors++;
                $display("FAIL dir_busy[%0d]: busy %0d cycles, expected %0d", i, bc, W + 1);
            end
            checks++;
            if (dc !== 1) begin
                errors++;
                $display("FAIL dir_done_count[%0d]: %0d pulses, expected 1", i, dc);
            end
            checks++;
            if (res !== ex[i]) begin
                errors++;
                $display("FAIL dir_result[%0d]: {Cout,S}=%h, expected %h", i, res, ex[i]);
            end
            repeat (3) @(negedge clk);
            checks++;
            if ({Cout, S} !== ex[i]) begin
                errors++;
                $display("FAIL dir_hold[%0d]: {Cout,S}=%h, expected %h", i, {Cout, S}, ex[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, bc, dc;
        logic [W:0] res, exp_r;
        logic [W-1:0] a, b;
        logic c;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            exp_r = model(a, b, c, 1'b0);
            do_op(a, b, c, 1'b0, lat, bc, dc, res);
            checks++;
            if (lat !== W || dc !== 1 || res !== exp_r) begin
                errors++;
                $display("FAIL rand[%0d] %h+%h+%b: lat=%0d done=%0d {Cout,S}=%h, expected lat=%0d done=1 %h",
                         i, a, b, c, lat, dc, res, W, exp_r);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dc;
        logic [W:0] res;
        @(negedge clk);
        A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
        @(negedge clk);                      // accepted, RUN cycle 1
        start = 1'b0;
        repeat (2) @(negedge clk);           // RUN cycle 3
        A = 8'hAA; B = 8'h55; Cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dc = 0; res = '0;
        for (int i = 0; i < 4 * W; i++) begin
            @(negedge clk);
            if (done) begin
                dc++;
                res = {Cout, S};
            end
        end
        checks++;
        if (dc !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: %0d pulses, expected 1", dc);
        end
        checks++;
        if (res !== 9'h046) begin
            errors++;
            $display("FAIL ignore_result: {Cout,S}=%h, expected 046", res);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_idle: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, dc;
        logic [W:0] res;
        @(negedge clk);
        A = 8'h80; B = 8'h80; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);           // RUN cycle 4
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, Cout, S} !== {3'b000, {W{1'b0}}}) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b Cout=%b S=%h, expected all zero",
                     busy, done, Cout, S);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, Cout, S} !== {3'b000, {W{1'b0}}}) begin
            errors++;
            $display("FAIL midrun_no_resume: busy=%b done=%b Cout=%b S=%h, expected all zero",
                     busy, done, Cout, S);
        end
        do_op(8'h01, 8'h02, 1'b0, 1'b0, lat, bc, dc, res);
        checks++;
        if (lat !== W || res !== 9'h003) begin
            errors++;
            $display("FAIL midrun_restart: lat=%0d {Cout,S}=%h, expected lat=%0d 003", lat, res, W);
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] exp_r;
        int ndone, last_t;
        start = 1'b1;
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
        exp_r = model(A, B, Cin, 1'b0);
        @(negedge clk);
        ndone = 0; last_t = -1;
        for (int t = 0; t < 8 * (W + 2) && ndone < 6; t++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                checks++;
                if ({Cout, S} !== exp_r) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: {Cout,S}=%h, expected %h", ndone, {Cout, S}, exp_r);
                end
                if (last_t >= 0) begin
                    checks++;
                    if (t - last_t !== W + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing[%0d]: %0d cycles, expected %0d", ndone, t - last_t, W + 2);
                    end
                end
                last_t = t;
                A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
                exp_r = model(A, B, Cin, 1'b0);
                if (ndone == 6) start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (ndone !== 6) begin
            errors++;
            $display("FAIL b2b_count: %0d operations completed, expected 6", ndone);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b, expected 0", busy);
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int lat, bc, dc;
        logic [W:0] res, exp_r;
        logic [W-1:0] a, b;
        do_op(8'h05, 8'h07, 1'b0, 1'b1, lat, bc, dc, res);
        checks++;
        if (res !== 9'h0FE) begin
            errors++;
            $display("FAIL sub_5_7: {Cout,S}=%h, expected 0FE", res);
        end
        do_op(8'h07, 8'h05, 1'b0, 1'b1, lat, bc, dc, res);
        checks++;
        if (res !== 9'h102) begin
            errors++;
            $display("FAIL sub_7_5: {Cout,S}=%h, expected 102", res);
        end
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom); b = W'($urandom);
            exp_r = model(a, b, 1'b0, 1'b1);
            do_op(a, b, 1'($urandom), 1'b1, lat, bc, dc, res);
            checks++;
            if (lat !== W || res !== exp_r) begin
                errors++;
                $display("FAIL sub_rand[%0d] %h-%h: lat=%0d {Cout,S}=%h, expected %h",
                         i, a, b, lat, res, exp_r);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_add_ctrl
